// File: rtl/game_draw_controller.sv
// game_draw_controller: sequences one draw of the game-index selector.
// It owns the 128-bit used register and a free-running 16-bit LFSR.
// Each accepted request captures a start index. A first-free-slot search
// (upward, wrapping 127 -> 0) then runs, and the result is committed with
// a one-cycle done pulse.
module game_draw_controller #(
    parameter int          NUM_GAMES = 128,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clear,
    input  logic         draw_req,
    input  logic         start_override,
    input  logic [6:0]   start_value,
    output logic         busy,
    output logic         done,
    output logic [6:0]   game_index,
    output logic         draw_err,
    output logic         exhausted,
    output logic [7:0]   games_drawn,
    output logic [127:0] used_array
);

    // Games at or above NUM_GAMES never exist, so they start out taken.
    localparam logic [127:0] INIT_MASK = ~((128'd1 << NUM_GAMES) - 128'd1);

    typedef enum logic [1:0] {
        IDLE,
        SELECT,
        COMMIT
    } state_t;

    state_t      state;
    logic [15:0] lfsr;
    logic [6:0]  start_q;
    logic [6:0]  idx_q;
    logic [6:0]  probe;
    logic [6:0]  sel_idx;
    logic        sel_valid;

    assign busy      = (state != IDLE);
    assign exhausted = (games_drawn == 8'(NUM_GAMES));

    // Fibonacci LFSR, x^16+x^14+x^13+x^11+1; clear does not disturb it
    always_ff @(posedge clock) begin
        if (reset) begin
            lfsr <= LFSR_SEED;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // First free slot at or above start_q, wrapping around the 7-bit index space
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        probe     = '0;
        for (int unsigned i = 0; i < 128; i++) begin
            probe = start_q + 7'(i);
            if (!sel_valid && !used_array[probe]) begin
                sel_valid = 1'b1;
                sel_idx   = probe;
            end
        end
    end

    // Draw sequencer: IDLE accepts, SELECT latches the search result, COMMIT marks it used
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            used_array  <= INIT_MASK;
            games_drawn <= '0;
            game_index  <= '0;
            done        <= 1'b0;
            draw_err    <= 1'b0;
            start_q     <= '0;
            idx_q       <= '0;
        end else begin
            done     <= 1'b0;
            draw_err <= 1'b0;
            if (clear) begin
                used_array  <= INIT_MASK;
                games_drawn <= '0;
                state       <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (draw_req) begin
                            if (exhausted) begin
                                draw_err <= 1'b1;
                            end else begin
                                start_q <= start_override ? start_value : lfsr[6:0];
                                state   <= SELECT;
                            end
                        end
                    end
                    SELECT: begin
                        if (sel_valid) begin
                            idx_q <= sel_idx;
                            state <= COMMIT;
                        end else begin
                            draw_err <= 1'b1;
                            state    <= IDLE;
                        end
                    end
                    COMMIT: begin
                        used_array[idx_q] <= 1'b1;
                        games_drawn       <= games_drawn + 8'd1;
                        game_index        <= idx_q;
                        done              <= 1'b1;
                        state             <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/game_draw_controller.md
Name: game_draw_controller

Overview:
Sequences the game-index selector for one round of play. Owns the 128-bit "game used" register and a free-running LFSR that supplies start indices. On each draw request it captures a start index and runs the combinational first-free-slot search (upward with wrap-around, instantiated internally). It then commits the chosen game as used and returns the index with a one-cycle done pulse. It sits between the game FSM (requester) and the selection datapath.

Parameters:
NUM_GAMES, 128, number of playable games (1..128). Bits NUM_GAMES..127 are permanently marked used.
LFSR_SEED, 16'hACE1, LFSR value loaded on reset. Must be non-zero.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high
clear  input  1  synchronous round restart: frees all games and aborts any in-flight draw
draw_req  input  1  request one draw; sampled only in IDLE
start_override  input  1  when 1 at acceptance, use start_value instead of LFSR[6:0]
start_value  input  7  deterministic start index (test/demo mode)
busy  output  1  high in SELECT and COMMIT
done  output  1  one-cycle pulse: game_index is a new valid draw
game_index  output  7  last drawn index; holds until next done
draw_err  output  1  one-cycle pulse: request rejected (exhausted) or search failed
exhausted  output  1  games_drawn == NUM_GAMES
games_drawn  output  8  games committed this round (0..128)
used_array  output  128  current used register; bit i = 1 means game i is taken

Behaviour:
- Reset (synchronous, highest priority):
  - state=IDLE, used_array=INIT_MASK (bits >= NUM_GAMES set, others 0), games_drawn=0, game_index=0.
  - done=0, draw_err=0, busy=0, exhausted=0 (NUM_GAMES>=1).
  - LFSR=LFSR_SEED.
- LFSR:
  - 16-bit Fibonacci, taps x^16+x^14+x^13+x^11+1.
  - Advances every cycle except during reset. Not affected by clear.
- clear (priority below reset, above everything else):
  - used_array=INIT_MASK, games_drawn=0, state=IDLE.
  - done and draw_err are forced 0 in the following cycle; game_index holds its value.
  - Any in-flight draw is discarded and produces no done.
  - draw_req in the same cycle as clear is ignored.
- FSM states IDLE, SELECT, COMMIT:
  - IDLE, draw_req=1, exhausted=0: capture start_q = start_override ? start_value : LFSR[6:0]; go to SELECT.
  - IDLE, draw_req=1, exhausted=1: pulse draw_err; stay in IDLE; no state change.
  - SELECT: the selector is evaluated on (used_array, start_q). It returns the first index >= start_q whose bit is 0, wrapping 127 -> 0.
    - valid=1: register idx_q; go to COMMIT.
    - valid=0 (defensive; unreachable when counts agree): pulse draw_err; go to IDLE.
  - COMMIT: set used_array[idx_q]=1, games_drawn+=1, game_index=idx_q, done=1 for one cycle; go to IDLE.
- Latency: the edge sampling draw_req is edge 1; done is high in the cycle after edge 3. The earliest next acceptance is the edge after done, so back-to-back throughput is one draw per 3 cycles.
- draw_req while busy is ignored (not queued). The requester holds or re-asserts it.
- done and draw_err are never high together.
- exhausted is combinational from games_drawn and updates in the same cycle games_drawn changes.
- games_drawn never exceeds NUM_GAMES. A start value >= NUM_GAMES is legal and wraps to the lowest free game.

Test Plan:
- Reset with NUM_GAMES=128 -> busy=0, done=0, draw_err=0, game_index=0, games_drawn=0, exhausted=0, used_array=0, all held until the first request.
- start_override=1, start_value=50, empty array, pulse draw_req -> done in the cycle after edge 3, game_index=50, used_array[50]=1, games_drawn=1. Repeat with start 50 -> game_index=51, games_drawn=2.
- Wrap: pre-draw index 127 (start 127), then draw with start 127 -> game_index=0. With NUM_GAMES=8, start_value=100 -> game_index=0.
- Exhaust, NUM_GAMES=4, LFSR starts, 4 draws -> four distinct indices in {0..3}, exhausted=1 after the 4th done. 5th draw_req -> draw_err pulse for one cycle, no done, used_array unchanged.
- Abort: draw_req accepted, clear asserted the next cycle (state SELECT) -> no done, no draw_err, used_array=INIT_MASK, games_drawn=0, state IDLE.
- clear and draw_req in the same cycle -> clear wins, busy stays 0, no done. A following draw_req is accepted normally.
